conv1d_sram_responder: RTL and testbench

Memory-side responder for the conv1d SRAM request/response interface. It owns a flip-flop word memory and serves two requesters on one clock:
- Port A: the conv1d accelerator's datapath fetch interface.
- Port B: host/bus preload and readback.

It round-robin arbitrates between them, returns a same-cycle grant, and returns a registered response one cycle after each grant. This is the endpoint that answers the accelerator's weight/input reads.

---
 rtl/conv1d_sram_responder_if.sv | 25 ++
 rtl/conv1d_sram_responder.sv | 150 +++++++++++++++
 tb/tb_conv1d_sram_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/conv1d_sram_responder_if.sv
// One requester port of the conv1d SRAM request/response bus.
// The requester drives req/we/addr/wdata/be; the responder drives gnt/rvalid/rdata/err.
interface conv1d_sram_responder_if #(
  parameter int AddrWidth = 32
);
  logic                 req;
  logic                 we;
  logic [AddrWidth-1:0] addr;
  logic [31:0]          wdata;
  logic [3:0]           be;
  logic                 gnt;
  logic                 rvalid;
  logic [31:0]          rdata;
  logic                 err;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/conv1d_sram_responder.sv
// Flip-flop word memory serving the conv1d datapath (port A) and host (port B)
// with round-robin arbitration, same-cycle grant and a registered one-cycle response.
module conv1d_sram_responder #(
  parameter int Depth     = 256,
  parameter int AddrWidth = 32
) (
  input  logic                   clk,
  input  logic                   reset_ni,
  conv1d_sram_responder_if.slave a_port,
  conv1d_sram_responder_if.slave b_port
);

  localparam int IdxW = $clog2(Depth);
  localparam int HiW  = AddrWidth - IdxW - 2;

  logic                 a_gnt_s;
  logic                 b_gnt_s;
  logic                 last_b_q;
  logic                 last_b_d;

  logic                 sel_we_s;
  logic [AddrWidth-1:0] sel_addr_s;
  logic [31:0]          sel_wdata_s;
  logic [3:0]           sel_be_s;
  logic [HiW-1:0]       sel_hi_s;
  logic [IdxW-1:0]      idx_s;
  logic                 in_range_s;
  logic                 mem_we_s;
  logic [31:0]          rd_word_s;
  logic [31:0]          merged_s;
  logic                 unused_addr_lsb_s;

  logic [31:0]          mem_q [Depth];

  logic                 a_rvalid_q, a_rvalid_d;
  logic [31:0]          a_rdata_q,  a_rdata_d;
  logic                 a_err_q,    a_err_d;
  logic                 b_rvalid_q, b_rvalid_d;
  logic [31:0]          b_rdata_q,  b_rdata_d;
  logic                 b_err_q,    b_err_d;

  // Arbitration: a lone requester wins; under contention the port not granted last wins.
  always_comb begin
    a_gnt_s  = 1'b0;
    b_gnt_s  = 1'b0;
    last_b_d = last_b_q;
    if (a_port.req && (!b_port.req || last_b_q)) begin
      a_gnt_s  = 1'b1;
      last_b_d = 1'b0;
    end else if (b_port.req) begin
      b_gnt_s  = 1'b1;
      last_b_d = 1'b1;
    end else begin
      last_b_d = last_b_q;
    end
  end

  // Route the granted port's request to the memory.
  always_comb begin
    if (b_gnt_s) begin
      sel_we_s    = b_port.we;
      sel_addr_s  = b_port.addr;
      sel_wdata_s = b_port.wdata;
      sel_be_s    = b_port.be;
    end else begin
      sel_we_s    = a_port.we;
      sel_addr_s  = a_port.addr;
      sel_wdata_s = a_port.wdata;
      sel_be_s    = a_port.be;
    end
  end

  // Decode word index and range; every bit above the index must be zero.
  always_comb begin
    sel_hi_s          = sel_addr_s[AddrWidth-1:IdxW+2];
    idx_s             = sel_addr_s[IdxW+1:2];
    in_range_s        = (sel_hi_s == {HiW{1'b0}});
    unused_addr_lsb_s = ^sel_addr_s[1:0];
    rd_word_s         = mem_q[idx_s];
    mem_we_s          = (a_gnt_s || b_gnt_s) && sel_we_s && in_range_s;
    merged_s          = rd_word_s;
    for (int k = 0; k < 4; k++) begin
      if (sel_be_s[k]) begin
        merged_s[8*k +: 8] = sel_wdata_s[8*k +: 8];
      end else begin
        merged_s[8*k +: 8] = rd_word_s[8*k +: 8];
      end
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= merged_s;
    end
  end

  // Next-state of the per-port response registers; rdata/err hold between pulses.
  always_comb begin
    a_rvalid_d = a_gnt_s;
    a_rdata_d  = a_rdata_q;
    a_err_d    = a_err_q;
    b_rvalid_d = b_gnt_s;
    b_rdata_d  = b_rdata_q;
    b_err_d    = b_err_q;
    if (a_gnt_s) begin
      a_err_d   = !in_range_s;
      a_rdata_d = (in_range_s && !sel_we_s) ? rd_word_s : 32'h0000_0000;
    end else begin
      a_err_d   = a_err_q;
    end
    if (b_gnt_s) begin
      b_err_d   = !in_range_s;
      b_rdata_d = (in_range_s && !sel_we_s) ? rd_word_s : 32'h0000_0000;
    end else begin
      b_err_d   = b_err_q;
    end
  end

  // Response and arbitration state; reset drops any pending response at once.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      last_b_q   <= 1'b1;
      a_rvalid_q <= 1'b0;
      a_rdata_q  <= 32'h0000_0000;
      a_err_q    <= 1'b0;
      b_rvalid_q <= 1'b0;
      b_rdata_q  <= 32'h0000_0000;
      b_err_q    <= 1'b0;
    end else begin
      last_b_q   <= last_b_d;
      a_rvalid_q <= a_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      a_err_q    <= a_err_d;
      b_rvalid_q <= b_rvalid_d;
      b_rdata_q  <= b_rdata_d;
      b_err_q    <= b_err_d;
    end
  end

  assign a_port.gnt    = a_gnt_s;
  assign a_port.rvalid = a_rvalid_q;
  assign a_port.rdata  = a_rdata_q;
  assign a_port.err    = a_err_q;
  assign b_port.gnt    = b_gnt_s;
  assign b_port.rvalid = b_rvalid_q;
  assign b_port.rdata  = b_rdata_q;
  assign b_port.err    = b_err_q;

endmodule

// File: tb/tb_conv1d_sram_responder.sv
// Directed self-checking bench for conv1d_sram_responder with hand-computed expectations.
module tb_conv1d_sram_responder;

  localparam int Depth = 256;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic reset_ni;
  int   checks = 0;
  int   errors = 0;

  conv1d_sram_responder_if #(.AddrWidth(AW)) a_if ();
  conv1d_sram_responder_if #(.AddrWidth(AW)) b_if ();

  conv1d_sram_responder #(.Depth(Depth), .AddrWidth(AW)) dut (
    .clk      (clk),
    .reset_ni (reset_ni),
    .a_port   (a_if.slave),
    .b_port   (b_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata; a_if.be = be;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata; b_if.be = be;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // One uncontended transfer: grant this cycle, response on the next.
  task automatic xfer(input bit use_b, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    if (use_b) set_b(1'b1, we, addr, wdata, be);
    else       set_a(1'b1, we, addr, wdata, be);
    #1;
    check_eq({tag, " gnt"},   use_b ? b_if.gnt : a_if.gnt, 32'd1);
    check_eq({tag, " other gnt"}, use_b ? a_if.gnt : b_if.gnt, 32'd0);
    tick();
    idle();
    check_eq({tag, " rvalid"}, use_b ? b_if.rvalid : a_if.rvalid, 32'd1);
    check_eq({tag, " rdata"},  use_b ? b_if.rdata  : a_if.rdata,  exp_rdata);
    check_eq({tag, " err"},    use_b ? b_if.err    : a_if.err,    {31'd0, exp_err});
  endtask

  initial begin
    logic prev_a;
    logic prev_b;
    reset_ni = 1'b0;
    idle();
    #12;
    check_eq("rst a_gnt",    a_if.gnt,    32'd0);
    check_eq("rst a_rvalid", a_if.rvalid, 32'd0);
    check_eq("rst a_rdata",  a_if.rdata,  32'd0);
    check_eq("rst a_err",    a_if.err,    32'd0);
    check_eq("rst b_rvalid", b_if.rvalid, 32'd0);
    check_eq("rst b_rdata",  b_if.rdata,  32'd0);
    check_eq("rst b_err",    b_if.err,    32'd0);
    @(negedge clk);
    reset_ni = 1'b1;
    tick();

    // Basic write from B, read back from A.
    xfer(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "b wr 0x10");
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "a rd 0x10");
    tick();
    check_eq("rvalid single pulse", a_if.rvalid, 32'd0);
    check_eq("rdata holds", a_if.rdata, 32'hDEADBEEF);
    xfer(1'b0, 1'b0, 32'h13, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "a rd 0x13 lsb ignored");

    // Byte enables: be=0101 replaces bytes 0 and 2; reads ignore be.
    xfer(1'b1, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, "b wr 0x20 full");
    xfer(1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0, "b wr 0x20 be5");
    xfer(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, "a rd 0x20 merged");

    // Range boundaries.
    xfer(1'b1, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "b wr word0");
    xfer(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1, "a rd 0x400 oor");
    xfer(1'b1, 1'b1, 32'h400, 32'h12345678, 4'hF, 32'h0, 1'b1, "b wr 0x400 oor");
    xfer(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "a rd word0 unchanged");
    xfer(1'b1, 1'b1, 32'h80000000, 32'h0BAD0BAD, 4'hF, 32'h0, 1'b1, "b wr hi-bit oor");
    xfer(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "a rd word0 no alias");
    xfer(1'b1, 1'b1, 32'h3FC, 32'h5A5A0001, 4'hF, 32'h0, 1'b0, "b wr last word");
    xfer(1'b0, 1'b0, 32'h3FC, 32'h0, 4'h0, 32'h5A5A0001, 1'b0, "a rd last word");

    // Streaming: preload eight words, then A reads them back to back.
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, 1'b1, 32'h40 + 32'(4 * i), 32'hA5000000 + 32'(i), 4'hF, 32'h0, 1'b0,
           $sformatf("preload %0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      set_a(1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0);
      #1;
      check_eq($sformatf("stream gnt %0d", i), a_if.gnt, 32'd1);
      if (i > 0) begin
        check_eq($sformatf("stream rvalid %0d", i - 1), a_if.rvalid, 32'd1);
        check_eq($sformatf("stream rdata %0d", i - 1), a_if.rdata, 32'hA5000000 + 32'(i - 1));
      end
      tick();
    end
    idle();
    check_eq("stream rvalid 7", a_if.rvalid, 32'd1);
    check_eq("stream rdata 7",  a_if.rdata,  32'hA5000007);
    tick();
    check_eq("stream end rvalid", a_if.rvalid, 32'd0);

    // Reset the cycle after an A grant; the pending response must vanish.
    set_a(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    #1;
    check_eq("pre-reset a_gnt", a_if.gnt, 32'd1);
    tick();
    idle();
    check_eq("pre-reset a_rvalid", a_if.rvalid, 32'd1);
    reset_ni = 1'b0;
    #1;
    check_eq("mid-reset a_rvalid", a_if.rvalid, 32'd0);
    check_eq("mid-reset a_rdata",  a_if.rdata,  32'd0);
    #3;
    reset_ni = 1'b1;
    tick();

    // Contention after reset: grants alternate starting with A.
    set_a(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    set_b(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    prev_a = 1'b0;
    prev_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq($sformatf("cont a_gnt %0d", i), a_if.gnt, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("cont b_gnt %0d", i), b_if.gnt, (i % 2 == 1) ? 32'd1 : 32'd0);
      check_eq($sformatf("cont a_rvalid %0d", i), a_if.rvalid, {31'd0, prev_a});
      check_eq($sformatf("cont b_rvalid %0d", i), b_if.rvalid, {31'd0, prev_b});
      check_eq($sformatf("cont dual rvalid %0d", i), a_if.rvalid & b_if.rvalid, 32'd0);
      if (prev_a) check_eq($sformatf("cont a_rdata %0d", i), a_if.rdata, 32'hDEADBEEF);
      if (prev_b) check_eq($sformatf("cont b_rdata %0d", i), b_if.rdata, 32'h11BB33DD);
      prev_a = (i % 2 == 0);
      prev_b = (i % 2 == 1);
      tick();
    end
    idle();
    check_eq("cont final a_rvalid", a_if.rvalid, 32'd0);
    check_eq("cont final b_rvalid", b_if.rvalid, 32'd1);
    check_eq("cont final b_rdata",  b_if.rdata,  32'h11BB33DD);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
